// File: rtl/fp_mul_seq.sv
// Sequential shift-add floating-point multiplier, 8-bit exponent, truncating.
// One operation in flight; valid/ready on both the operand and result sides.
module fp_mul_seq #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam int M  = DATA_W - 8;
    localparam int F  = DATA_W - 9;
    localparam int CW = $clog2(M + 1);

    localparam logic [DATA_W-1:0] QNAN = {1'b0, 8'hFF, 1'b1, {(F-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        MUL,
        NORM,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2*M-1:0]    acc;
    logic [2*M-1:0]    mcand;
    logic [M-1:0]      mplier;
    logic [CW-1:0]     cnt;
    logic signed [9:0] esum;
    logic              out_valid_q;
    logic [DATA_W-1:0] result_q;
    logic [3:0]        flags_q;

    logic accept;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // Operand classification, evaluated on the registered pair
    logic         sa, sb, sx;
    logic [7:0]   ea, eb;
    logic [F-1:0] fa, fb;
    logic         a_nan, b_nan, a_inf, b_inf;
    logic         a_zero, b_zero, a_den, b_den;
    logic         any_nan, any_snan, special;

    assign sa = a_q[DATA_W-1];
    assign sb = b_q[DATA_W-1];
    assign sx = sa ^ sb;
    assign ea = a_q[DATA_W-2:DATA_W-9];
    assign eb = b_q[DATA_W-2:DATA_W-9];
    assign fa = a_q[F-1:0];
    assign fb = b_q[F-1:0];

    assign a_nan  = (&ea) && (|fa);
    assign b_nan  = (&eb) && (|fb);
    assign a_inf  = (&ea) && !(|fa);
    assign b_inf  = (&eb) && !(|fb);
    // Denormals are flushed, so any zero exponent counts as zero
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_den  = (ea == 8'd0) && (|fa);
    assign b_den  = (eb == 8'd0) && (|fb);

    assign any_nan  = a_nan || b_nan;
    assign any_snan = (a_nan && !fa[F-1]) || (b_nan && !fb[F-1]);
    assign special  = any_nan || a_inf || b_inf || a_zero || b_zero;

    logic signed [9:0] esum_new;

    assign esum_new = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    // Normalisation of the finished product
    logic              p_top;
    logic [M-1:0]      mant;
    logic [M-1:0]      trunc_unused;
    logic signed [9:0] e_fin;

    always_comb begin
        p_top = acc[2*M-1];
        {mant, trunc_unused} = p_top ? acc : {acc[2*M-2:0], 1'b0};
        e_fin = esum + $signed({9'd0, p_top});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                state_nx = special ? DONE : MUL;
            end
            MUL: begin
                if (cnt == CW'(M - 1)) begin
                    state_nx = NORM;
                end
            end
            NORM: begin
                state_nx = DONE;
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            esum        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        flags_q <= '0;
                    end
                end
                CHECK: begin
                    flags_q[0] <= a_den || b_den;
                    if (any_nan) begin
                        result_q   <= QNAN;
                        flags_q[3] <= any_snan;
                    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                        result_q   <= QNAN;
                        flags_q[3] <= 1'b1;
                    end else if (a_inf || b_inf) begin
                        result_q <= {sx, 8'hFF, {F{1'b0}}};
                    end else if (a_zero || b_zero) begin
                        result_q <= {sx, {(DATA_W-1){1'b0}}};
                    end else begin
                        acc    <= '0;
                        cnt    <= '0;
                        esum   <= esum_new;
                        mcand  <= {{M{1'b0}}, 1'b1, fa};
                        mplier <= {1'b1, fb};
                    end
                end
                MUL: begin
                    acc    <= acc + (mplier[0] ? mcand : '0);
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                NORM: begin
                    if (e_fin >= 10'sd255) begin
                        result_q   <= {sx, 8'hFF, {F{1'b0}}};
                        flags_q[2] <= 1'b1;
                    end else if (e_fin <= 10'sd0) begin
                        result_q   <= {sx, {(DATA_W-1){1'b0}}};
                        flags_q[1] <= 1'b1;
                    end else begin
                        result_q <= {sx, e_fin[7:0], mant[M-2:0]};
                    end
                end
                DONE: begin
                    // Result register settles one edge before it is offered
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq at DATA_W=32.
// Directed corner cases plus random pairs against a behavioural model.
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    fp_mul_seq #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic on the IEEE-style fields
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f,
                                  output int lat);
        logic        s;
        int          ea, eb, e;
        logic [22:0] fa, fb;
        bit          an, bn, ai, bi, az, bz, den, snan;
        logic [47:0] p;
        logic [23:0] mant;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
        az = (ea == 0);
        bz = (eb == 0);
        den  = (ea == 0 && fa != 0) || (eb == 0 && fb != 0);
        snan = (an && !fa[22]) || (bn && !fb[22]);
        f = {1'b0, 1'b0, 1'b0, den};
        lat = 2;
        if (an || bn) begin
            r = 32'h7FC00000;
            f[3] = snan;
        end else if ((ai && bz) || (bi && az)) begin
            r = 32'h7FC00000;
            f[3] = 1'b1;
        end else if (ai || bi) begin
            r = {s, 8'hFF, 23'd0};
        end else if (az || bz) begin
            r = {s, 31'd0};
        end else begin
            lat = 27;
            p = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
            e = ea + eb - 127;
            if (p >= 48'h8000_0000_0000) begin
                mant = 24'(p / 48'h100_0000);
                e = e + 1;
            end else begin
                mant = 24'(p / 48'h80_0000);
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};
                f[2] = 1'b1;
            end else if (e <= 0) begin
                r = {s, 31'd0};
                f[1] = 1'b1;
            end else begin
                r = {s, 8'(e), mant[22:0]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        int          k;
        logic [7:0]  e;
        logic [22:0] fr;
        k  = $urandom_range(0, 9);
        fr = 23'($urandom);
        if (k == 0) begin
            e = 8'd0;
            if ($urandom_range(0, 1) == 0) fr = '0;
        end else if (k == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) fr = '0;
        end else if (k == 2) begin
            e = 8'($urandom_range(1, 254));
        end else begin
            e = 8'($urandom_range(90, 165));
        end
        return {1'($urandom), e, fr};
    endfunction

    // Drives one pair and waits for out_valid; leaves the result unacknowledged
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] f,
                         output int lat, output bit to);
        int n;
        to  = 1'b0;
        lat = 0;
        r   = '0;
        f   = '0;
        n   = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            to = 1'b1;
            return;
        end
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) to = 1'b1;
        r = result;
        f = flags;
    endtask

    task automatic take();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op_a = '0;
        op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        checks++;
        if (result !== 32'd0) begin
            errors++;
            $display("FAIL reset_result got=%h want=0", result);
        end
        checks++;
        if (flags !== 4'd0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=0000", flags);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [6] = '{32'h3FC00000, 32'h7F800000, 32'h7F800001,
                                32'h7F7FFFFF, 32'h00800000, 32'h80000001};
        logic [31:0] vb [6] = '{32'h40000000, 32'h00000000, 32'h3F800000,
                                32'h40000000, 32'h00800000, 32'h40000000};
        logic [31:0] vr [6] = '{32'h40400000, 32'h7FC00000, 32'h7FC00000,
                                32'h7F800000, 32'h00000000, 32'h80000000};
        logic [3:0]  vf [6] = '{4'b0000, 4'b1000, 4'b1000,
                                4'b0100, 4'b0010, 4'b0001};
        int          vl [6] = '{27, 2, 2, 27, 27, 2};
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        bit          to;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], r, f, lat, to);
            checks++;
            if (to || r !== vr[i]) begin
                errors++;
                $display("FAIL dir%0d_result got=%h want=%h to=%0d", i, r, vr[i], to);
            end
            checks++;
            if (f !== vf[i]) begin
                errors++;
                $display("FAIL dir%0d_flags got=%b want=%b", i, f, vf[i]);
            end
            checks++;
            if (lat != vl[i]) begin
                errors++;
                $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, vl[i]);
            end
            take();
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, er;
        logic [3:0]  f, ef;
        int          lat, el;
        bit          to;
        for (int i = 0; i < 60; i++) begin
            a = rand_op();
            b = rand_op();
            model(a, b, er, ef, el);
            do_op(a, b, r, f, lat, to);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            checks++;
            if (to || r !== er || f !== ef || lat != el) begin
                errors++;
                $display("FAIL rand%0d a=%h b=%h got=%h/%b/%0d want=%h/%b/%0d",
                         i, a, b, r, f, lat, er, ef, el);
            end
            take();
        end
    endtask

    task automatic test_stall();
        logic [31:0] r, er;
        logic [3:0]  f, ef;
        int          lat, el;
        bit          to;
        do_op(32'h3FC00000, 32'h40000000, r, f, lat, to);
        checks++;
        if (to || r !== 32'h40400000) begin
            errors++;
            $display("FAIL stall_first got=%h want=40400000", r);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            op_a = $urandom;
            op_b = $urandom;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 32'h40400000 || flags !== 4'b0000
                || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got=%b/%h/%b/%b want=1/40400000/0000/0",
                         i, out_valid, result, flags, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        take();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got=%b want=0", out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_no_extra got=%b/%b want=0/1", out_valid, in_ready);
        end
        model(32'h40000000, 32'h40400000, er, ef, el);
        do_op(32'h40000000, 32'h40400000, r, f, lat, to);
        checks++;
        if (to || r !== er || f !== ef || lat != el) begin
            errors++;
            $display("FAIL stall_next got=%h/%b/%0d want=%h/%b/%0d", r, f, lat, er, ef, el);
        end
        take();
    endtask

    task automatic test_rst_abort();
        logic [31:0] r;
        logic [3:0]  f;
        int          lat, seen;
        bit          to;
        @(negedge clk);
        op_a = 32'h3FC00000;
        op_b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_ready_in_rst got=%b want=0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready_after got=%b want=1", in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_output got=%0d want=0", seen);
        end
        do_op(32'h3F800000, 32'h3F800000, r, f, lat, to);
        checks++;
        if (to || r !== 32'h3F800000 || f !== 4'b0000 || lat != 27) begin
            errors++;
            $display("FAIL abort_next got=%h/%b/%0d want=3f800000/0000/27", r, f, lat);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || flags !== 4'd0) begin
            errors++;
            $display("FAIL abort_in_done got=%b/%h/%b want=0/0/0", out_valid, result, flags);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(32'h80000001, 32'h40000000, r, f, lat, to);
        checks++;
        if (to || r !== 32'h80000000 || f !== 4'b0001 || lat != 2) begin
            errors++;
            $display("FAIL abort_after_done got=%h/%b/%0d want=80000000/0001/2", r, f, lat);
        end
        take();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_rst_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
